othello_turn_controller: RTL and testbench

- Parametrised top-level game sequencer for the Othello design.
- Runs welcome → start debounce → board initialisation → rotating player turns → game over.
- Supports N players, pass handling (no legal move), optional per-turn timeout, and automatic end after a full round of consecutive passes.
- Drives the new-move controller and the board initialiser; sits directly under the top level.

---
 rtl/othello_turn_controller_if.sv | 30 +++
 rtl/othello_turn_controller.sv | 126 ++++++++++++
 tb/tb_othello_turn_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/othello_turn_controller_if.sv
// Purpose : bundles the game-sequencer handshake and status signals into one port.
// Latency : none (wiring only); the controller drives the slave-side outputs from flops.
// Backpressure: none; go and init_end are levels, ack is a pulse, and status outputs are levels/pulses.
// Ports   : go/init_end/ack/no_move/game_end go from master to slave;
//           init_start/new_move/player/timeout/pass_cnt/game_over go from slave to master.
interface othello_turn_controller_if #(
    parameter int PW = 1
);
    logic          go;
    logic          init_end;
    logic          ack;
    logic          no_move;
    logic          game_end;
    logic          init_start;
    logic          new_move;
    logic [PW-1:0] player;
    logic          timeout;
    logic [PW:0]   pass_cnt;
    logic          game_over;

    modport master (
        output go, init_end, ack, no_move, game_end,
        input  init_start, new_move, player, timeout, pass_cnt, game_over
    );

    modport slave (
        input  go, init_end, ack, no_move, game_end,
        output init_start, new_move, player, timeout, pass_cnt, game_over
    );
endinterface

// File: rtl/othello_turn_controller.sv
// Purpose : game sequencer running welcome, press-release start, board init, rotating turns and game over.
// Latency : every input is sampled at a clock edge and affects the outputs one cycle later; no comb in->out path.
// Backpressure: none; the controller only reacts to level/pulse inputs and never stalls its sources.
// Ports   : clock, reset (sync, active high); bus = slave side of othello_turn_controller_if.
module othello_turn_controller #(
    parameter int NUM_PLAYERS    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clock,
    input  logic reset,
    othello_turn_controller_if.slave bus
);
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [PW-1:0] LAST_P  = PW'(NUM_PLAYERS - 1);
    localparam logic [PW:0]   NP_C    = (PW + 1)'(NUM_PLAYERS);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [2:0] WELC = 3'd0;
    localparam logic [2:0] ARM  = 3'd1;
    localparam logic [2:0] INIT = 3'd2;
    localparam logic [2:0] TURN = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;
    localparam logic [2:0] OVER = 3'd5;

    logic [2:0]    state_q,   state_d;
    logic [PW-1:0] player_q,  player_d;
    logic [PW:0]   pass_q,    pass_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          timeout_q, timeout_d;

    logic expired;
    logic advance;
    logic pass_ev;

    // Expiry is only possible when a timeout is configured.
    assign expired = (TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        pass_d    = pass_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        advance   = 1'b0;
        pass_ev   = 1'b0;

        case (state_q)
            WELC: if (bus.go) state_d = ARM;
            // Waiting for release makes a start (or restart) a full press-release.
            ARM:  if (!bus.go) state_d = INIT;
            INIT: begin
                if (bus.init_end) begin
                    state_d  = TURN;
                    player_d = '0;
                    pass_d   = '0;
                    timer_d  = '0;
                end
            end
            TURN: begin
                if (bus.game_end) begin
                    state_d = OVER;
                end else if (bus.ack) begin
                    pass_d  = '0;
                    advance = 1'b1;
                end else if (bus.no_move) begin
                    pass_ev = 1'b1;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    pass_ev   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && timer_q != TO_LAST) begin
                    // Saturating count; expiry forces an advance before it could wrap.
                    timer_d = timer_q + 1'b1;
                end

                if (pass_ev) begin
                    // A full round of consecutive passes ends the game.
                    if (pass_q + 1'b1 == NP_C) begin
                        state_d = OVER;
                        pass_d  = NP_C;
                    end else begin
                        pass_d  = pass_q + 1'b1;
                        advance = 1'b1;
                    end
                end

                if (advance) begin
                    player_d = (player_q == LAST_P) ? '0 : player_q + 1'b1;
                    timer_d  = '0;
                    state_d  = GAP;
                end
            end
            // One idle cycle so the move controller sees a fresh new_move edge per turn.
            GAP: begin
                timer_d = '0;
                state_d = TURN;
            end
            OVER: if (bus.go) state_d = ARM;
            default: state_d = WELC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= WELC;
            player_q  <= '0;
            pass_q    <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            pass_q    <= pass_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.init_start = (state_q == INIT);
    assign bus.new_move   = (state_q == TURN);
    assign bus.game_over  = (state_q == OVER);
    assign bus.player     = player_q;
    assign bus.pass_cnt   = pass_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_othello_turn_controller.sv
// Purpose : exercises a 2-player/10-cycle-timeout instance and a 3-player/no-timeout instance.
// Latency : expected turn-start, timeout and game-over events are queued by the stimulus and popped by monitors.
// Backpressure: not applicable; inputs change 1 time unit after posedge, outputs are sampled on negedge.
module tb_othello_turn_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    othello_turn_controller_if #(.PW(1)) if2 ();
    othello_turn_controller_if #(.PW(2)) if3 ();

    othello_turn_controller #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(10)) u2 (
        .clock (clk),
        .reset (rst),
        .bus   (if2.slave)
    );

    othello_turn_controller #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(0)) u3 (
        .clock (clk),
        .reset (rst),
        .bus   (if3.slave)
    );

    // kind: 0 = turn start (new_move rise), 1 = timeout pulse, 2 = game over rise
    typedef struct {
        int kind;
        int player;
        int pass;
    } ev_t;

    ev_t q2[$];
    ev_t q3[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int dut, input int kind, input int pl, input int pc);
        ev_t e;
        e.kind   = kind;
        e.player = pl;
        e.pass   = pc;
        if (dut == 2) q2.push_back(e);
        else q3.push_back(e);
    endtask

    task automatic mon_event(input int dut, input int kind, input int pl, input int pc);
        ev_t e;
        int  empty;
        empty = (dut == 2) ? (q2.size() == 0) : (q3.size() == 0);
        if (empty != 0) begin
            n_total++;
            $display("FAIL dut%0d unexpected event: kind %0d player %0d pass %0d, expected none",
                     dut, kind, pl, pc);
        end else begin
            if (dut == 2) e = q2.pop_front();
            else e = q3.pop_front();
            check($sformatf("dut%0d event kind", dut), kind, e.kind);
            check($sformatf("dut%0d event player", dut), pl, e.player);
            check($sformatf("dut%0d event pass_cnt", dut), pc, e.pass);
        end
    endtask

    logic nm2_prev = 1'b0, go2_prev = 1'b0;
    logic nm3_prev = 1'b0, go3_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (if2.timeout) mon_event(2, 1, int'(if2.player), int'(if2.pass_cnt));
            if (if2.new_move && !nm2_prev) mon_event(2, 0, int'(if2.player), int'(if2.pass_cnt));
            if (if2.game_over && !go2_prev) mon_event(2, 2, int'(if2.player), int'(if2.pass_cnt));
            if (if3.timeout) mon_event(3, 1, int'(if3.player), int'(if3.pass_cnt));
            if (if3.new_move && !nm3_prev) mon_event(3, 0, int'(if3.player), int'(if3.pass_cnt));
            if (if3.game_over && !go3_prev) mon_event(3, 2, int'(if3.player), int'(if3.pass_cnt));
        end
        nm2_prev = if2.new_move;
        go2_prev = if2.game_over;
        nm3_prev = if3.new_move;
        go3_prev = if3.game_over;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset2(input string tag);
        check({tag, " init_start"}, int'(if2.init_start), 0);
        check({tag, " new_move"},   int'(if2.new_move),   0);
        check({tag, " timeout"},    int'(if2.timeout),    0);
        check({tag, " game_over"},  int'(if2.game_over),  0);
        check({tag, " player"},     int'(if2.player),     0);
        check({tag, " pass_cnt"},   int'(if2.pass_cnt),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        {if2.go, if2.init_end, if2.ack, if2.no_move, if2.game_end} = '0;
        {if3.go, if3.init_end, if3.ack, if3.no_move, if3.game_end} = '0;
        rst = 1'b1;
        step(2);
        check_reset2("reset dut2");
        check("reset dut3 new_move", int'(if3.new_move), 0);
        check("reset dut3 pass_cnt", int'(if3.pass_cnt), 0);
        rst = 1'b0;

        // ---- dut2: start sequence ----
        if2.go = 1'b1;
        step(3);
        check("ARM holds while go high", int'(if2.init_start), 0);
        if2.go = 1'b0;
        step(1);
        check("INIT init_start", int'(if2.init_start), 1);
        check("INIT new_move", int'(if2.new_move), 0);
        step(4);
        check("INIT still waiting", int'(if2.init_start), 1);
        if2.init_end = 1'b1;
        push(2, 0, 0, 0);
        step(1);
        if2.init_end = 1'b0;
        check("TURN new_move", int'(if2.new_move), 1);
        check("TURN init_start low", int'(if2.init_start), 0);
        check("TURN game_over low", int'(if2.game_over), 0);

        // ---- dut2: four acked turns, players 0,1,0,1 -> 0 ----
        for (int i = 0; i < 4; i++) begin
            if2.ack = 1'b1;
            push(2, 0, (i + 1) % 2, 0);
            step(1);
            if2.ack = 1'b0;
            check("GAP new_move low", int'(if2.new_move), 0);
            step(1);
            check("new_move back high", int'(if2.new_move), 1);
        end

        // ---- dut2: timeout expires on the 10th idle TURN cycle ----
        push(2, 1, 1, 1);
        push(2, 0, 1, 1);
        step(9);
        check("no timeout before expiry", int'(if2.new_move), 1);
        step(1);
        check("timeout pulse", int'(if2.timeout), 1);
        step(1);
        check("timeout one cycle", int'(if2.timeout), 0);

        // ---- dut2: ack exactly on the expiry cycle wins ----
        step(9);
        if2.ack = 1'b1;
        push(2, 0, 0, 0);
        step(1);
        if2.ack = 1'b0;
        check("ack on expiry no timeout", int'(if2.timeout), 0);
        check("ack on expiry pass_cnt", int'(if2.pass_cnt), 0);
        step(1);

        // ---- dut2: game_end beats ack ----
        if2.ack      = 1'b1;
        if2.game_end = 1'b1;
        push(2, 2, 0, 0);
        step(1);
        if2.ack      = 1'b0;
        if2.game_end = 1'b0;
        check("OVER game_over", int'(if2.game_over), 1);
        check("OVER new_move", int'(if2.new_move), 0);
        step(2);
        check("OVER holds", int'(if2.game_over), 1);

        // ---- dut2: restart by press-release ----
        if2.go = 1'b1;
        step(1);
        if2.go = 1'b0;
        step(1);
        check("restart INIT", int'(if2.init_start), 1);
        if2.init_end = 1'b1;
        push(2, 0, 0, 0);
        step(1);
        if2.init_end = 1'b0;

        // ---- dut2: reset mid-turn ----
        if2.no_move = 1'b1;
        push(2, 0, 1, 1);
        step(1);
        if2.no_move = 1'b0;
        step(2);
        check("pre-reset player", int'(if2.player), 1);
        check("pre-reset pass_cnt", int'(if2.pass_cnt), 1);
        rst        = 1'b1;
        if2.ack    = 1'b1;
        step(1);
        rst        = 1'b0;
        if2.ack    = 1'b0;
        check_reset2("mid-turn reset");
        if2.go = 1'b1;
        step(4);
        check("go held stays ARM init_start", int'(if2.init_start), 0);
        check("go held stays ARM new_move", int'(if2.new_move), 0);
        if2.go = 1'b0;
        step(2);

        // ---- dut3: three players, no timeout ----
        if3.go = 1'b1;
        step(1);
        if3.go = 1'b0;
        step(1);
        check("dut3 INIT", int'(if3.init_start), 1);
        if3.init_end = 1'b1;
        push(3, 0, 0, 0);
        step(1);
        if3.init_end = 1'b0;
        step(20);
        check("dut3 idle turn stays on player 0", int'(if3.player), 0);

        if3.no_move = 1'b1; push(3, 0, 1, 1); step(1); if3.no_move = 1'b0; step(1);
        if3.ack     = 1'b1; push(3, 0, 2, 0); step(1); if3.ack     = 1'b0; step(1);
        if3.no_move = 1'b1; push(3, 0, 0, 1); step(1); if3.no_move = 1'b0; step(1);
        if3.no_move = 1'b1; push(3, 0, 1, 2); step(1); if3.no_move = 1'b0; step(1);
        if3.no_move = 1'b1; push(3, 2, 1, 3); step(1); if3.no_move = 1'b0;
        check("dut3 game_over", int'(if3.game_over), 1);
        check("dut3 pass_cnt", int'(if3.pass_cnt), 3);
        check("dut3 player", int'(if3.player), 1);
        check("dut3 new_move low", int'(if3.new_move), 0);
        step(3);

        check("dut2 queue drained", q2.size(), 0);
        check("dut3 queue drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
